// File: rtl/if_pkg.sv
// if_pkg: shared types for the instruction-fetch stage.
package if_pkg;
  localparam int PC_W = 9;
  typedef logic [PC_W-1:0] pc_t;
  typedef enum logic [1:0] {SEL_HOLD, SEL_ABS, SEL_REL, SEL_INC} next_sel_e;
endpackage

// File: rtl/pc_next_logic.sv
// pc_next_logic: combinational next-PC selection (Halt > Branch > BranchRel > increment).
// Relative branching is built only when IF_REL_BRANCH_EN is defined.
module pc_next_logic
  import if_pkg::*;
#(
  parameter int PC_W = if_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic            halt,
  input  logic            branch,
`ifdef IF_REL_BRANCH_EN
  input  logic            branch_rel,
  input  logic            alu_flag,
`endif
  input  logic [PC_W-1:0] target,
  output next_sel_e       sel,
  output logic [PC_W-1:0] pc_next
);
`ifdef IF_REL_BRANCH_EN
  assign sel = halt ? SEL_HOLD : branch ? SEL_ABS : (branch_rel && alu_flag) ? SEL_REL : SEL_INC;
`else
  assign sel = halt ? SEL_HOLD : branch ? SEL_ABS : SEL_INC;
`endif
  // Two's-complement Target makes a plain modulo add cover backward jumps.
  always_comb begin
    pc_next = sel == SEL_HOLD ? pc :
              sel == SEL_ABS  ? target :
              sel == SEL_REL  ? pc + target : pc + PC_W'(1);
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: program counter register with async active-low Init and Halt freeze.
// Optional relative branch via IF_REL_BRANCH_EN (adds BranchRel, AluFlag).
module instr_fetch
  import if_pkg::*;
#(
  parameter int              PC_W     = if_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            Init,
  input  logic            Halt,
  input  logic            Branch,
`ifdef IF_REL_BRANCH_EN
  input  logic            BranchRel,
  input  logic            AluFlag,
`endif
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] PC,
  output logic            Halted
);
  next_sel_e       sel;
  logic [PC_W-1:0] pc_next;
  pc_next_logic #(.PC_W(PC_W)) u_next (
    .pc(PC),
    .halt(Halt),
    .branch(Branch),
`ifdef IF_REL_BRANCH_EN
    .branch_rel(BranchRel),
    .alu_flag(AluFlag),
`endif
    .target(Target),
    .sel(sel),
    .pc_next(pc_next)
  );
  always_ff @(posedge clk or negedge Init) begin
    if (!Init) begin
      PC     <= RESET_PC;
      Halted <= 1'b0;
    end else begin
      PC     <= pc_next;
      Halted <= sel == SEL_HOLD;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed plus randomized checks of instr_fetch against a behavioural model.
module tb_instr_fetch;
  logic       clk = 0, Init = 0, Halt = 0, Branch = 0;
  logic       BranchRel = 0, AluFlag = 0;
  logic [8:0] Target = 0;
  logic [8:0] PC;
  logic       Halted;
  int checks = 0, failures = 0;
  int m_pc = 0;
  bit m_h = 0;
  instr_fetch dut (
    .clk(clk), .Init(Init), .Halt(Halt), .Branch(Branch),
`ifdef IF_REL_BRANCH_EN
    .BranchRel(BranchRel), .AluFlag(AluFlag),
`endif
    .Target(Target), .PC(PC), .Halted(Halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  // Reference: priority rules expressed directly as integer arithmetic modulo 512.
  always @(posedge clk or negedge Init) begin
    if (!Init) begin
      m_pc <= 0;
      m_h  <= 0;
    end else if (Halt) m_h <= 1;
    else begin
      m_h <= 0;
      if (Branch) m_pc <= int'(Target);
`ifdef IF_REL_BRANCH_EN
      else if (BranchRel && AluFlag)
        m_pc <= (m_pc + (Target >= 256 ? int'(Target) - 512 : int'(Target)) + 512) % 512;
`endif
      else m_pc <= (m_pc + 1) % 512;
    end
  end
  always @(negedge clk) begin
    chk("pc_model", int'(PC), m_pc);
    chk("halted_model", int'(Halted), int'(m_h));
  end
  task automatic cyc(input logic h, input logic b, input logic [8:0] t);
    Halt = h; Branch = b; Target = t;
    @(posedge clk); #1;
  endtask
  initial begin
    Halt = 0; Branch = 1; Target = 10;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_pc", int'(PC), 0);
      chk("reset_halted", int'(Halted), 0);
    end
    Branch = 0; Init = 1;
    cyc(0, 0, 0); chk("first_inc", int'(PC), 1);
    cyc(0, 0, 0); chk("second_inc", int'(PC), 2);
    Init = 0; #1; Init = 1;
    cyc(0, 0, 0); chk("pc_1", int'(PC), 1);
    cyc(0, 1, 10); chk("branch_10", int'(PC), 10);
    cyc(0, 0, 10); chk("after_branch", int'(PC), 11);
    repeat (3) begin
      cyc(1, 1, 3);
      chk("halt_pc", int'(PC), 11);
      chk("halt_flag", int'(Halted), 1);
    end
    cyc(0, 0, 0);
    chk("resume_pc", int'(PC), 12);
    chk("resume_flag", int'(Halted), 0);
    cyc(0, 1, 511); chk("branch_511", int'(PC), 511);
    cyc(0, 0, 0); chk("wrap", int'(PC), 0);
    cyc(0, 1, 0); chk("self_loop", int'(PC), 0);
    cyc(0, 1, 199);
    cyc(0, 0, 0); chk("pc_200", int'(PC), 200);
    Branch = 1; Target = 77;
    #2 Init = 0;
    #1 chk("async_reset", int'(PC), 0);
    Branch = 0; Init = 1;
    cyc(0, 0, 0); chk("post_async", int'(PC), 1);
`ifdef IF_REL_BRANCH_EN
    cyc(0, 1, 10);
    BranchRel = 1; AluFlag = 0;
    cyc(0, 0, 5); chk("rel_noflag", int'(PC), 11);
    AluFlag = 1;
    cyc(0, 0, 5); chk("rel_fwd", int'(PC), 16);
    cyc(0, 0, 9'h1FE); chk("rel_back", int'(PC), 14);
    cyc(0, 1, 100); chk("abs_over_rel", int'(PC), 100);
    cyc(1, 0, 7); chk("halt_over_rel", int'(PC), 100);
    BranchRel = 0; AluFlag = 0;
`endif
    for (int i = 0; i < 600; i++) begin
      BranchRel = $urandom_range(0, 1);
      AluFlag   = $urandom_range(0, 1);
      if ($urandom_range(0, 39) == 0) begin
        #($urandom_range(1, 7)) Init = 0;
        #1 Init = 1;
      end
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, 9'($urandom));
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
